// File: rtl/display_scan_controller.sv
// Multiplexed seven-segment scan sequencer with a blanking gap per slot and leading-zero suppression.
// Optional digit blinking for time-set editing is enabled by defining DISPLAY_BLINK_EN.
module display_scan_controller #(
  parameter int NUM_DIGITS   = 5,
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int AP_INDEX     = 0,
  parameter int LZB_INDEX    = 4
`ifdef DISPLAY_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 100
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digitValues,
`ifdef DISPLAY_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blinkMask,
`endif
  output logic [3:0]              hexNumber,
  output logic                    apSelect,
  output logic [NUM_DIGITS-1:0]   anodeActiveLow,
  output logic                    frameStart
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(SLOT_CYCLES);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t                  state;
  logic [CW-1:0]           slot_count;
  logic [IW-1:0]           digit_index;
  logic [4*NUM_DIGITS-1:0] frame_latch;

  logic [CW-1:0]           slot_next;
  logic [IW-1:0]           index_next;
  logic [4*NUM_DIGITS-1:0] latch_next;
  logic                    frame_wrap;
  logic [3:0]              hex_next;
  logic                    show_next;
  logic                    suppress;
  logic                    blinked;
  logic [NUM_DIGITS-1:0]   onehot;
  logic [NUM_DIGITS-1:0]   anode_next;

`ifdef DISPLAY_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [FW-1:0]         frame_count, fcount_next;
  logic                  blink_phase, phase_next;
  logic [NUM_DIGITS-1:0] mask_latch, mask_next;
`endif

  // Next-slot computation: anode and data outputs are registered from these values,
  // so the data always changes on the same edge the anodes go dark.
  always_comb begin
    slot_next  = '0;
    index_next = '0;
    latch_next = frame_latch;
    frame_wrap = 1'b0;
    if (state == IDLE) begin
      frame_wrap = 1'b1;
      latch_next = digitValues;
    end else if (slot_count == CW'(SLOT_CYCLES - 1)) begin
      if (digit_index == IW'(NUM_DIGITS - 1)) begin
        frame_wrap = 1'b1;
        latch_next = digitValues;
      end else begin
        index_next = digit_index + 1'b1;
      end
    end else begin
      slot_next  = slot_count + 1'b1;
      index_next = digit_index;
    end

    hex_next  = latch_next[{index_next, 2'b00} +: 4];
    show_next = (slot_next >= CW'(BLANK_CYCLES));
    suppress  = (int'(index_next) == LZB_INDEX) && (hex_next == 4'd0);

`ifdef DISPLAY_BLINK_EN
    fcount_next = frame_count;
    phase_next  = blink_phase;
    mask_next   = mask_latch;
    if (state == IDLE) begin
      fcount_next = '0;
      phase_next  = 1'b1;
      mask_next   = blinkMask;
    end else if (frame_wrap) begin
      mask_next = blinkMask;
      if (int'(frame_count) == BLINK_FRAMES - 1) begin
        fcount_next = '0;
        phase_next  = ~blink_phase;
      end else begin
        fcount_next = frame_count + 1'b1;
      end
    end
    blinked = !phase_next && mask_next[index_next];
`else
    blinked = 1'b0;
`endif

    onehot             = '0;
    onehot[index_next] = 1'b1;
    anode_next         = (show_next && !suppress && !blinked) ? ~onehot : '1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      slot_count     <= '0;
      digit_index    <= '0;
      frame_latch    <= '0;
      hexNumber      <= '0;
      apSelect       <= 1'b0;
      anodeActiveLow <= '1;
      frameStart     <= 1'b0;
`ifdef DISPLAY_BLINK_EN
      frame_count    <= '0;
      blink_phase    <= 1'b1;
      mask_latch     <= '0;
`endif
    end else if (!enable) begin
      state          <= IDLE;
      slot_count     <= '0;
      digit_index    <= '0;
      hexNumber      <= '0;
      apSelect       <= 1'b0;
      anodeActiveLow <= '1;
      frameStart     <= 1'b0;
    end else begin
      state          <= show_next ? SHOW : BLANK;
      slot_count     <= slot_next;
      digit_index    <= index_next;
      frame_latch    <= latch_next;
      hexNumber      <= hex_next;
      apSelect       <= (int'(index_next) == AP_INDEX);
      anodeActiveLow <= anode_next;
      frameStart     <= frame_wrap;
`ifdef DISPLAY_BLINK_EN
      frame_count    <= fcount_next;
      blink_phase    <= phase_next;
      mask_latch     <= mask_next;
`endif
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: per-cycle expected output records queued per frame and compared.
// Blink coverage is included when DISPLAY_BLINK_EN is defined.
module tb_display_scan_controller;

  localparam int ND    = 5;
  localparam int SLOT  = 8;
  localparam int BLANK = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic [4*ND-1:0] digitValues;
  logic [3:0]      hexNumber;
  logic            apSelect;
  logic [ND-1:0]   anodeActiveLow;
  logic            frameStart;

  always #5 clk = ~clk;

`ifdef DISPLAY_BLINK_EN
  logic [ND-1:0] blinkMask;
  display_scan_controller #(
    .NUM_DIGITS(ND), .SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK),
    .AP_INDEX(0), .LZB_INDEX(4), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .digitValues(digitValues),
    .blinkMask(blinkMask), .hexNumber(hexNumber), .apSelect(apSelect),
    .anodeActiveLow(anodeActiveLow), .frameStart(frameStart)
  );
`else
  display_scan_controller #(
    .NUM_DIGITS(ND), .SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK),
    .AP_INDEX(0), .LZB_INDEX(4)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .digitValues(digitValues),
    .hexNumber(hexNumber), .apSelect(apSelect),
    .anodeActiveLow(anodeActiveLow), .frameStart(frameStart)
  );
`endif

  typedef struct packed {
    logic [3:0]    hex;
    logic          ap;
    logic [ND-1:0] an;
    logic          fs;
  } exp_t;

  typedef struct {
    logic [4*ND-1:0] vals;
    string           name;
  } vec_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check_val(input string name, input exp_t got, input exp_t want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got hex=%h ap=%b an=%b fs=%b want hex=%h ap=%b an=%b fs=%b",
               name, got.hex, got.ap, got.an, got.fs, want.hex, want.ap, want.an, want.fs);
    end
  endtask

  // One frame of expected outputs, derived from the slot timing of the scan.
  task automatic push_frame(input logic [4*ND-1:0] vals, input logic [ND-1:0] dark);
    exp_t e;
    for (int s = 0; s < ND; s++) begin
      for (int c = 0; c < SLOT; c++) begin
        e.hex = vals[4*s +: 4];
        e.ap  = (s == 0);
        e.fs  = (s == 0) && (c == 0);
        if (c < BLANK || (s == 4 && e.hex == 4'd0) || dark[s]) e.an = '1;
        else e.an = ~(ND'(1) << s);
        q.push_back(e);
      end
    end
  endtask

  task automatic run_cycles(input int n, input string name);
    exp_t got, want;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      got = {hexNumber, apSelect, anodeActiveLow, frameStart};
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL %s expected-queue empty at cycle %0d", name, i);
      end else begin
        want = q.pop_front();
        check_val(name, got, want);
      end
    end
  endtask

  task automatic restart(input logic [4*ND-1:0] vals);
    exp_t got;
    enable = 1'b0;
    @(negedge clk);
    got = {hexNumber, apSelect, anodeActiveLow, frameStart};
    check_val("idle", got, '{hex: 4'd0, ap: 1'b0, an: '1, fs: 1'b0});
    digitValues = vals;
    enable      = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[4];
    exp_t got;
    vecs[0] = '{20'h12341, "basic_scan"};
    vecs[1] = '{20'h02341, "lzb_zero"};
    vecs[2] = '{20'h90870, "slot0_zero"};
    vecs[3] = '{20'hF0A5B, "mixed"};

    reset       = 1'b1;
    enable      = 1'b0;
    digitValues = '0;
`ifdef DISPLAY_BLINK_EN
    blinkMask   = '0;
`endif
    repeat (3) @(negedge clk);
    got = {hexNumber, apSelect, anodeActiveLow, frameStart};
    check_val("reset_state", got, '{hex: 4'd0, ap: 1'b0, an: '1, fs: 1'b0});
    reset = 1'b0;

    foreach (vecs[i]) begin
      restart(vecs[i].vals);
      push_frame(vecs[i].vals, '0);
      push_frame(vecs[i].vals, '0);
      run_cycles(2 * ND * SLOT, vecs[i].name);
    end

    // Mid-frame update lands only at the next frame boundary.
    restart(20'h12341);
    push_frame(20'h12341, '0);
    push_frame(20'h56789, '0);
    run_cycles(20, "midframe_old");
    digitValues = 20'h56789;
    run_cycles(60, "midframe_new");

    // Enable drop during SHOW of slot 3.
    restart(20'h43219);
    push_frame(20'h43219, '0);
    run_cycles(28, "pre_drop");
    q.delete();
    enable = 1'b0;
    @(negedge clk);
    got = {hexNumber, apSelect, anodeActiveLow, frameStart};
    checks++;
    if (anodeActiveLow !== '1 || frameStart !== 1'b0) begin
      failures++;
      $display("FAIL enable_drop got an=%b fs=%b want an=11111 fs=0", got.an, got.fs);
    end
    enable = 1'b1;
    push_frame(20'h43219, '0);
    run_cycles(40, "reenable");

    // Asynchronous reset mid-SHOW, off the clock edge.
    restart(20'h13571);
    push_frame(20'h13571, '0);
    run_cycles(13, "pre_reset");
    q.delete();
    #2;
    reset = 1'b1;
    #1;
    got = {hexNumber, apSelect, anodeActiveLow, frameStart};
    check_val("async_reset", got, '{hex: 4'd0, ap: 1'b0, an: '1, fs: 1'b0});
    @(negedge clk);
    reset = 1'b0;
    push_frame(20'h13571, '0);
    run_cycles(40, "post_reset");

`ifdef DISPLAY_BLINK_EN
    blinkMask = 5'b00011;
    restart(20'h12345);
    for (int f = 0; f < 6; f++)
      push_frame(20'h12345, (f == 2 || f == 3) ? 5'b00011 : 5'b00000);
    run_cycles(6 * ND * SLOT, "blink");
    blinkMask = '0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
